// File: rtl/ex_stage.sv
// ex_stage: MIPS32 execute stage. It holds the ID/EX register, the ALU, an iterative
//   32-step MULT/MULTU unit with its HI/LO registers, and the EX/MEM register.
// Latency: an ALU instruction reaches mem_* one edge after it enters EX. MULT/MULTU
//   stays in EX for MUL_CYCLES+2 cycles and raises stall_req_o for MUL_CYCLES+1 of them.
// Backpressure: stall_i freezes every register and the FSM. stall_req_o holds upstream
//   and pushes bubbles into EX/MEM.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   stall_i, flush_i    - downstream hold; load a NOP into ID/EX and abort a multiply
//   id_*_i              - decoded instruction (aluop, alusel, operands, dest, write enable)
//   ex_*_o              - combinational forwarding of the instruction currently in EX
//   mem_*_o             - EX/MEM register
//   stall_req_o         - upstream hold request while a multiply is in progress
module ex_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [7:0]  id_aluop_i,
  input  logic [2:0]  id_alusel_i,
  input  logic [31:0] id_reg1_i,
  input  logic [31:0] id_reg2_i,
  input  logic [4:0]  id_wd_i,
  input  logic        id_wreg_i,
  output logic [4:0]  ex_wd_o,
  output logic        ex_wreg_o,
  output logic [31:0] ex_wdata_o,
  output logic [4:0]  mem_wd_o,
  output logic        mem_wreg_o,
  output logic [31:0] mem_wdata_o,
  output logic        stall_req_o
);

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;
  localparam logic [2:0] SEL_MUL   = 3'b101;

  localparam logic [7:0] OP_AND  = 8'b00100100;
  localparam logic [7:0] OP_OR   = 8'b00100101;
  localparam logic [7:0] OP_XOR  = 8'b00100110;
  localparam logic [7:0] OP_NOR  = 8'b00100111;
  localparam logic [7:0] OP_SLL  = 8'b01111100;
  localparam logic [7:0] OP_SRL  = 8'b00000010;
  localparam logic [7:0] OP_SRA  = 8'b00000011;
  localparam logic [7:0] OP_MFHI = 8'b00010000;
  localparam logic [7:0] OP_MFLO = 8'b00010010;
  localparam logic [7:0] OP_ADDU = 8'b00100001;
  localparam logic [7:0] OP_SUBU = 8'b00100011;
  localparam logic [7:0] OP_SLT  = 8'b00101010;
  localparam logic [7:0] OP_SLTU = 8'b00101011;
  localparam logic [7:0] OP_MULT = 8'b00011000;

  localparam int            CW       = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_aluop;
  logic [2:0]    r_alusel;
  logic [31:0]   r_reg1, r_reg2;
  logic [4:0]    r_wd;
  logic          r_wreg;
  logic [31:0]   r_hi, r_lo;
  logic [4:0]    r_mem_wd;
  logic          r_mem_wreg;
  logic [31:0]   r_mem_wdata;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_mcand, r_acc;
  logic [31:0]   r_mplier;
  logic          r_sign;

  logic [31:0]   w_alu;
  logic [4:0]    w_sh;
  logic          w_signed;
  logic [31:0]   w_mag1, w_mag2;
  logic [63:0]   w_product;

  assign w_sh = r_reg1[4:0];

  always_comb begin
    w_alu = 32'd0;
    case (r_alusel)
      SEL_LOGIC: case (r_aluop)
        OP_AND:  w_alu = r_reg1 & r_reg2;
        OP_OR:   w_alu = r_reg1 | r_reg2;
        OP_XOR:  w_alu = r_reg1 ^ r_reg2;
        OP_NOR:  w_alu = ~(r_reg1 | r_reg2);
        default: w_alu = 32'd0;
      endcase
      SEL_SHIFT: case (r_aluop)
        OP_SLL:  w_alu = r_reg2 << w_sh;
        OP_SRL:  w_alu = r_reg2 >> w_sh;
        OP_SRA:  w_alu = $signed(r_reg2) >>> w_sh;
        default: w_alu = 32'd0;
      endcase
      SEL_MOVE: case (r_aluop)
        OP_MFHI: w_alu = r_hi;
        OP_MFLO: w_alu = r_lo;
        default: w_alu = 32'd0;
      endcase
      SEL_ARITH: case (r_aluop)
        OP_ADDU: w_alu = r_reg1 + r_reg2;
        OP_SUBU: w_alu = r_reg1 - r_reg2;
        OP_SLT:  w_alu = {31'd0, $signed(r_reg1) < $signed(r_reg2)};
        OP_SLTU: w_alu = {31'd0, r_reg1 < r_reg2};
        default: w_alu = 32'd0;
      endcase
      default: w_alu = 32'd0;
    endcase
  end

  // MULT runs the unsigned shift-add on magnitudes and fixes the sign at the end.
  assign w_signed  = (r_aluop == OP_MULT);
  assign w_mag1    = (w_signed && r_reg1[31]) ? (~r_reg1 + 32'd1) : r_reg1;
  assign w_mag2    = (w_signed && r_reg2[31]) ? (~r_reg2 + 32'd1) : r_reg2;
  assign w_product = r_sign ? (~r_acc + 64'd1) : r_acc;

  // A multiply writes HI/LO, not a GPR, so it never forwards.
  assign ex_wd_o     = r_wd;
  assign ex_wreg_o   = r_wreg & (r_alusel != SEL_MUL);
  assign ex_wdata_o  = w_alu;
  assign mem_wd_o    = r_mem_wd;
  assign mem_wreg_o  = r_mem_wreg;
  assign mem_wdata_o = r_mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else if (!stall_i) r_state <= w_state_nxt;
  end

  // DONE drops the stall request so that the following instruction loads on the same
  // edge that commits HI/LO. A MFHI/MFLO right behind the multiply sees the new values.
  always_comb begin
    w_state_nxt = r_state;
    stall_req_o = 1'b0;
    case (r_state)
      S_IDLE: if (r_alusel == SEL_MUL) begin
        stall_req_o = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        stall_req_o = 1'b1;
        if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush_i) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aluop     <= 8'd0;
      r_alusel    <= 3'd0;
      r_reg1      <= 32'd0;
      r_reg2      <= 32'd0;
      r_wd        <= 5'd0;
      r_wreg      <= 1'b0;
      r_mem_wd    <= 5'd0;
      r_mem_wreg  <= 1'b0;
      r_mem_wdata <= 32'd0;
    end else if (!stall_i) begin
      if (flush_i) begin
        r_aluop  <= 8'd0;
        r_alusel <= 3'd0;
        r_reg1   <= 32'd0;
        r_reg2   <= 32'd0;
        r_wd     <= 5'd0;
        r_wreg   <= 1'b0;
      end else if (!stall_req_o) begin
        r_aluop  <= id_aluop_i;
        r_alusel <= id_alusel_i;
        r_reg1   <= id_reg1_i;
        r_reg2   <= id_reg2_i;
        r_wd     <= id_wd_i;
        r_wreg   <= id_wreg_i;
      end
      if (stall_req_o) begin
        r_mem_wd    <= 5'd0;
        r_mem_wreg  <= 1'b0;
        r_mem_wdata <= 32'd0;
      end else begin
        r_mem_wd    <= ex_wd_o;
        r_mem_wreg  <= ex_wreg_o;
        r_mem_wdata <= ex_wdata_o;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_cnt    <= '0;
      r_mcand  <= 64'd0;
      r_mplier <= 32'd0;
      r_acc    <= 64'd0;
      r_sign   <= 1'b0;
    end else if (!stall_i) begin
      case (r_state)
        S_IDLE: if (w_state_nxt == S_RUN) begin
          r_mcand  <= {32'd0, w_mag1};
          r_mplier <= w_mag2;
          r_sign   <= w_signed & (r_reg1[31] ^ r_reg2[31]);
          r_acc    <= 64'd0;
          r_cnt    <= '0;
        end
        S_RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end
        S_DONE: if (!flush_i) {r_hi, r_lo} <= w_product;
        default: ;
      endcase
    end
  end

endmodule
